// File: rtl/lsu_mem_ctrl.sv
// Load/store unit memory controller: one outstanding request, alignment and
// range checks, byte-lane shifting and load extension over a 64-bit memory port.
module lsu_mem_ctrl #(
  parameter logic [63:0] PMEM_BASE = 64'h8000_0000,
  parameter logic [63:0] PMEM_SIZE = 64'h0800_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic [1:0]  resp_fault,
  output logic        men,
  output logic        mwen,
  output logic [63:0] raddr,
  input  logic [63:0] rdata,
  output logic [63:0] waddr,
  output logic [63:0] wdata,
  output logic [7:0]  wmask
);

  localparam int unsigned XW = 64;
  localparam logic [1:0] FAULT_OK  = 2'd0;
  localparam logic [1:0] FAULT_MIS = 2'd1;
  localparam logic [1:0] FAULT_OOR = 2'd2;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e          state_q, state_d;
  logic            wen_q, wen_d;
  logic [XW-1:0]   addr_q, addr_d;
  logic [XW-1:0]   wdata_q, wdata_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic [XW-1:0]   rdata_q, rdata_d;
  logic [1:0]      fault_q, fault_d;

  logic            misalign;
  logic            out_of_range;
  logic [1:0]      req_fault;
  logic [3:0]      nbytes;
  logic [XW:0]     end_ext;
  logic [XW:0]     limit_ext;
  logic [5:0]      lane_sh;
  logic [XW-1:0]   ld_shifted;
  logic [XW-1:0]   ld_ext;
  logic [7:0]      mask_raw;
  logic            in_access;

  // Request checks; the 65-bit end address makes wrap-around land out of range.
  always_comb begin
    nbytes    = 4'd1 << req_size;
    end_ext   = {1'b0, req_addr} + 65'(nbytes);
    limit_ext = {1'b0, PMEM_BASE} + {1'b0, PMEM_SIZE};
    unique case (req_size)
      2'd0:    misalign = 1'b0;
      2'd1:    misalign = req_addr[0];
      2'd2:    misalign = |req_addr[1:0];
      default: misalign = |req_addr[2:0];
    endcase
    out_of_range = (req_addr < PMEM_BASE) || (end_ext > limit_ext);
    req_fault    = misalign ? FAULT_MIS : (out_of_range ? FAULT_OOR : FAULT_OK);
  end

  // Lane extraction and extension of the returned dword.
  always_comb begin
    lane_sh    = {addr_q[2:0], 3'b000};
    ld_shifted = rdata >> lane_sh;
    unique case (size_q)
      2'd0:    ld_ext = uns_q ? {56'd0, ld_shifted[7:0]}  : {{56{ld_shifted[7]}},  ld_shifted[7:0]};
      2'd1:    ld_ext = uns_q ? {48'd0, ld_shifted[15:0]} : {{48{ld_shifted[15]}}, ld_shifted[15:0]};
      2'd2:    ld_ext = uns_q ? {32'd0, ld_shifted[31:0]} : {{32{ld_shifted[31]}}, ld_shifted[31:0]};
      default: ld_ext = ld_shifted;
    endcase
    unique case (size_q)
      2'd0:    mask_raw = 8'h01;
      2'd1:    mask_raw = 8'h03;
      2'd2:    mask_raw = 8'h0F;
      default: mask_raw = 8'hFF;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      rdata_q <= '0;
      fault_q <= FAULT_OK;
    end else begin
      state_q <= state_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          rdata_d = '0;
          fault_d = req_fault;
          if (req_fault != FAULT_OK) begin
            state_d = RESP;
          end else begin
            wen_d   = req_wen;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            size_d  = req_size;
            uns_d   = req_unsigned;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        rdata_d = wen_q ? '0 : ld_ext;
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory port is driven only while ACCESS is the current state.
  assign in_access  = (state_q == ACCESS);
  assign men        = in_access;
  assign mwen       = in_access && wen_q;
  assign raddr      = in_access ? {addr_q[63:3], 3'b000} : '0;
  assign waddr      = in_access ? {addr_q[63:3], 3'b000} : '0;
  assign wdata      = in_access ? (wdata_q << lane_sh) : '0;
  assign wmask      = (in_access && wen_q) ? (mask_raw << addr_q[2:0]) : 8'h00;
  assign req_ready  = (state_q == IDLE) && !rst;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_fault = fault_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed vector bench for lsu_mem_ctrl with a single-dword memory stub.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready;
  logic [63:0] resp_rdata;
  logic [1:0]  resp_fault;
  logic        men, mwen;
  logic [63:0] raddr, rdata, waddr, wdata;
  logic [7:0]  wmask;

  logic [63:0] mem_addr, mem_word;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Memory stub: returns junk unless the DUT reads the expected dword.
  assign rdata = (men && !mwen && raddr == mem_addr) ? mem_word : 64'hDEAD_BEEF_DEAD_BEEF;

  lsu_mem_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .men(men), .mwen(mwen), .raddr(raddr), .rdata(rdata),
    .waddr(waddr), .wdata(wdata), .wmask(wmask)
  );

  typedef struct {
    logic        wen;
    logic [63:0] addr;
    logic [63:0] wd;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] mem;
    logic        exp_men;
    logic [7:0]  exp_mask;
    logic [63:0] exp_wd;
    logic [63:0] exp_rd;
    logic [1:0]  exp_fault;
  } vec_t;

  vec_t vt [15];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Presents a request and returns #1 after the accepting edge.
  task automatic issue(input vec_t v, input logic rr);
    mem_addr = {v.addr[63:3], 3'b000};
    mem_word = v.mem;
    @(negedge clk);
    req_valid = 1'b1; req_wen = v.wen; req_addr = v.addr; req_wdata = v.wd;
    req_size = v.size; req_unsigned = v.uns; resp_ready = rr;
    for (int i = 0; i < 8 && !req_ready; i++) @(negedge clk);
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic run_vec(input int k, input vec_t v);
    issue(v, 1'b1);
    chk($sformatf("v%0d_men", k), 64'(men), 64'(v.exp_men));
    if (v.exp_men) begin
      chk($sformatf("v%0d_mwen", k), 64'(mwen), 64'(v.wen));
      chk($sformatf("v%0d_raddr", k), raddr, {v.addr[63:3], 3'b000});
      chk($sformatf("v%0d_waddr", k), waddr, {v.addr[63:3], 3'b000});
      chk($sformatf("v%0d_wmask", k), 64'(wmask), 64'(v.exp_mask));
      chk($sformatf("v%0d_wdata", k), wdata, v.exp_wd);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_men_drop", k), 64'(men), 64'd0);
    end
    chk($sformatf("v%0d_resp_valid", k), 64'(resp_valid), 64'd1);
    chk($sformatf("v%0d_rdata", k), resp_rdata, v.exp_rd);
    chk($sformatf("v%0d_fault", k), 64'(resp_fault), 64'(v.exp_fault));
    chk($sformatf("v%0d_ready_in_resp", k), 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    chk($sformatf("v%0d_resp_done", k), 64'(resp_valid), 64'd0);
    chk($sformatf("v%0d_ready_after", k), 64'(req_ready), 64'd1);
  endtask

  initial begin
    //        wen   addr                    wdata                   sz    uns   mem                     men   mask   exp_wdata               exp_rdata               fault
    vt[0]  = '{1'b0, 64'h0000_0000_8000_0003, 64'h0,                  2'd0, 1'b0, 64'h0000_0000_8000_0000, 1'b1, 8'h00, 64'h0,                  64'hFFFF_FFFF_FFFF_FF80, 2'd0};
    vt[1]  = '{1'b1, 64'h0000_0000_8000_0006, 64'h0000_0000_0000_ABCD, 2'd1, 1'b0, 64'h0,                  1'b1, 8'hC0, 64'hABCD_0000_0000_0000, 64'h0,                  2'd0};
    vt[2]  = '{1'b0, 64'h0000_0000_8000_0002, 64'h0,                  2'd2, 1'b0, 64'h0,                  1'b0, 8'h00, 64'h0,                  64'h0,                  2'd1};
    vt[3]  = '{1'b0, 64'h0000_0000_87FF_FFFC, 64'h0,                  2'd3, 1'b0, 64'h0,                  1'b0, 8'h00, 64'h0,                  64'h0,                  2'd1};
    vt[4]  = '{1'b0, 64'h0000_0000_8800_0000, 64'h0,                  2'd3, 1'b0, 64'h0,                  1'b0, 8'h00, 64'h0,                  64'h0,                  2'd2};
    vt[5]  = '{1'b0, 64'h0000_0000_8000_0003, 64'h0,                  2'd0, 1'b1, 64'h0000_0000_8000_0000, 1'b1, 8'h00, 64'h0,                  64'h0000_0000_0000_0080, 2'd0};
    vt[6]  = '{1'b0, 64'h0000_0000_8000_0004, 64'h0,                  2'd1, 1'b0, 64'h1234_8001_0000_0000, 1'b1, 8'h00, 64'h0,                  64'hFFFF_FFFF_FFFF_8001, 2'd0};
    vt[7]  = '{1'b0, 64'h0000_0000_8000_0004, 64'h0,                  2'd2, 1'b1, 64'h1234_8001_0000_0000, 1'b1, 8'h00, 64'h0,                  64'h0000_0000_1234_8001, 2'd0};
    vt[8]  = '{1'b0, 64'h0000_0000_8000_0004, 64'h0,                  2'd2, 1'b0, 64'h8765_4321_0000_0000, 1'b1, 8'h00, 64'h0,                  64'hFFFF_FFFF_8765_4321, 2'd0};
    vt[9]  = '{1'b0, 64'h0000_0000_87FF_FFF8, 64'h0,                  2'd3, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b1, 8'h00, 64'h0,                  64'h0123_4567_89AB_CDEF, 2'd0};
    vt[10] = '{1'b0, 64'h0000_0000_7FFF_FFFF, 64'h0,                  2'd0, 1'b0, 64'h0,                  1'b0, 8'h00, 64'h0,                  64'h0,                  2'd2};
    vt[11] = '{1'b1, 64'h0000_0000_8000_0008, 64'h1122_3344_5566_7788, 2'd3, 1'b0, 64'h0,                  1'b1, 8'hFF, 64'h1122_3344_5566_7788, 64'h0,                  2'd0};
    vt[12] = '{1'b1, 64'h0000_0000_8000_0001, 64'hFFFF_FFFF_FFFF_FF5A, 2'd0, 1'b0, 64'h0,                  1'b1, 8'h02, 64'hFFFF_FFFF_FFFF_5A00, 64'h0,                  2'd0};
    vt[13] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0000_0000_1234_5678, 2'd2, 1'b0, 64'h0,                  1'b0, 8'h00, 64'h0,                  64'h0,                  2'd2};
    vt[14] = '{1'b1, 64'h0000_0000_8000_0001, 64'h0000_0000_0000_1234, 2'd1, 1'b0, 64'h0,                  1'b0, 8'h00, 64'h0,                  64'h0,                  2'd1};

    rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = 2'd0; req_unsigned = 1'b0; resp_ready = 1'b1;
    mem_addr = '0; mem_word = '0;
    #1;
    chk("rst_men", 64'(men), 64'd0);
    chk("rst_mwen", 64'(mwen), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_req_ready", 64'(req_ready), 64'd1);
    chk("post_rst_rdata", resp_rdata, 64'd0);
    chk("post_rst_fault", 64'(resp_fault), 64'd0);

    for (int k = 0; k < 15; k++) run_vec(k, vt[k]);

    // Response back-pressure: held 5 cycles, outputs must not move.
    issue(vt[6], 1'b0);
    @(posedge clk);
    #1;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("hold%0d_resp_valid", c), 64'(resp_valid), 64'd1);
      chk($sformatf("hold%0d_rdata", c), resp_rdata, 64'hFFFF_FFFF_FFFF_8001);
      chk($sformatf("hold%0d_req_ready", c), 64'(req_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hold_release_ready", 64'(req_ready), 64'd1);

    // Asynchronous reset in the middle of ACCESS drops the operation.
    issue(vt[0], 1'b1);
    chk("rstacc_men_before", 64'(men), 64'd1);
    rst = 1'b1;
    #1;
    chk("rstacc_men", 64'(men), 64'd0);
    chk("rstacc_req_ready", 64'(req_ready), 64'd0);
    chk("rstacc_resp_valid", 64'(resp_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstacc_ready_after", 64'(req_ready), 64'd1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("rstacc_no_resp%0d", c), 64'(resp_valid), 64'd0);
    end
    run_vec(99, vt[8]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
